// File: rtl/buffer_arb_pkg.sv
// Shared types and defaults for the capture-buffer RAM arbiter.
package buffer_arb_pkg;

  localparam int unsigned DefaultDepth = 3500;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFlush
  } drn_state_e;

  typedef enum logic [1:0] {
    ReqCap,
    ReqDrn,
    ReqHost
  } req_id_e;

endpackage

// File: rtl/drain_skid_fifo.sv
// Two-entry valid/ready buffer decoupling drain RAM reads from the consumer.
module drain_skid_fifo #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  ready_i,
  output logic [1:0]            occupancy_o
);

  logic [DATA_WIDTH-1:0] mem_q [2];
  logic [DATA_WIDTH-1:0] mem_d [2];
  logic                  wr_q, wr_d, rd_q, rd_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  pop, push_ok;

  assign valid_o     = (cnt_q != 2'd0);
  assign data_o      = mem_q[rd_q];
  assign occupancy_o = cnt_q;

  // Next-state: simultaneous push and pop keep the count unchanged.
  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    pop     = valid_o & ready_i;
    push_ok = push_i & ((cnt_q != 2'd2) | pop);
    if (push_ok) begin
      mem_d[wr_q] = push_data_i;
      wr_d        = ~wr_q;
    end
    if (pop) begin
      rd_d = ~rd_q;
    end
    cnt_d = cnt_q + {1'b0, push_ok} - {1'b0, pop};
  end

  // Storage and pointers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/buffer_access_arbiter.sv
// Serialises capture writes, drain reads and host reads onto one RAM port.
module buffer_access_arbiter
  import buffer_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DEPTH      = DefaultDepth
) (
  input  logic                  s00_axi_aclk,
  input  logic                  s00_axi_areset,
  input  logic                  cap_req,
  input  logic [DATA_WIDTH-1:0] cap_data,
  output logic                  cap_ack,
  input  logic                  clear,
  input  logic                  drn_start,
  output logic                  drn_valid,
  output logic [DATA_WIDTH-1:0] drn_data,
  input  logic                  drn_ready,
  output logic                  drn_busy,
  output logic                  drn_done,
  input  logic                  host_req,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  output logic                  host_ack,
  output logic                  host_rvalid,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic [ADDR_WIDTH:0]   fill_count,
  output logic                  full,
  output logic                  overflow,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [ADDR_WIDTH:0] DepthCnt = (ADDR_WIDTH + 1)'(DEPTH);

  drn_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, wr_base;
  logic [ADDR_WIDTH:0]   fill_q, fill_d, fill_base, len_q, len_d, rd_ptr_q, rd_ptr_d;
  logic                  overflow_q, overflow_d, last_host_q, last_host_d;
  logic                  drn_pend_q, drn_pend_d, host_pend_q, host_pend_d;
  logic                  host_oob_q, host_oob_d, host_rvalid_q, host_rvalid_d;
  logic [DATA_WIDTH-1:0] host_rdata_q, host_rdata_d;
  logic                  active, clear_eff, full_eff, cap_wr, drn_rq, host_rq;
  logic                  drn_gnt, host_gnt, skid_pop;
  logic [1:0]            occ;
  logic [2:0]            outstanding;
  req_id_e               grant_id;

  drain_skid_fifo #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk_i       (s00_axi_aclk),
    .rst_i       (s00_axi_areset),
    .push_i      (drn_pend_q),
    .push_data_i (mem_rdata),
    .valid_o     (drn_valid),
    .data_o      (drn_data),
    .ready_i     (drn_ready),
    .occupancy_o (occ)
  );

  assign fill_count  = fill_q;
  assign full        = (fill_q == DepthCnt);
  assign overflow    = overflow_q;
  assign drn_busy    = (state_q != StIdle);
  assign host_rvalid = host_rvalid_q;
  assign host_rdata  = host_rdata_q;

  // Grant selection and combinational RAM port; gated so reset silences the port at once.
  always_comb begin
    active    = ~s00_axi_areset;
    clear_eff = clear & (state_q == StIdle);
    fill_base = clear_eff ? '0 : fill_q;
    wr_base   = clear_eff ? '0 : wr_ptr_q;
    full_eff  = (fill_base == DepthCnt);
    cap_ack   = active & cap_req;
    cap_wr    = cap_ack & ~full_eff;
    skid_pop  = drn_valid & drn_ready;
    // Credit counts a word leaving the skid this cycle so a ready sink sees 1 word/cycle.
    outstanding = {1'b0, occ} + {2'b0, drn_pend_q} - {2'b0, skid_pop};
    drn_rq    = active & (state_q == StRun) & (rd_ptr_q < len_q) & (outstanding < 3'd2);
    host_rq   = active & host_req;
    // On a tie the requester that did not win last time gets the slot.
    drn_gnt   = ~cap_wr & drn_rq & (~host_rq | last_host_q);
    host_gnt  = ~cap_wr & host_rq & (~drn_rq | ~last_host_q);
    host_ack  = host_gnt;
    drn_done  = (state_q == StFlush) & (occ == 2'd0) & ~drn_pend_q;

    grant_id = ReqCap;
    if (drn_gnt) grant_id = ReqDrn;
    if (host_gnt) grant_id = ReqHost;

    mem_en    = cap_wr | drn_gnt | host_gnt;
    mem_we    = cap_wr;
    mem_wdata = cap_wr ? cap_data : '0;
    mem_addr  = '0;
    if (mem_en) begin
      unique case (grant_id)
        ReqCap:  mem_addr = wr_base;
        ReqDrn:  mem_addr = rd_ptr_q[ADDR_WIDTH-1:0];
        ReqHost: mem_addr = host_addr;
        default: mem_addr = '0;
      endcase
    end
  end

  // Next-state for pointers, counters, read pipeline and drain FSM.
  always_comb begin
    wr_ptr_d      = wr_base + ADDR_WIDTH'(cap_wr);
    fill_d        = fill_base + (ADDR_WIDTH + 1)'(cap_wr);
    overflow_d    = (clear_eff ? 1'b0 : overflow_q) | (cap_ack & full_eff);
    last_host_d   = last_host_q;
    if (drn_gnt) last_host_d = 1'b0;
    if (host_gnt) last_host_d = 1'b1;
    drn_pend_d    = drn_gnt;
    host_pend_d   = host_gnt;
    host_oob_d    = ({1'b0, host_addr} >= fill_q);
    host_rvalid_d = host_pend_q;
    host_rdata_d  = (host_pend_q & ~host_oob_q) ? mem_rdata : '0;

    state_d  = state_q;
    len_d    = len_q;
    rd_ptr_d = rd_ptr_q;
    unique case (state_q)
      StIdle: begin
        if (drn_start) begin
          len_d    = fill_q;
          rd_ptr_d = '0;
          state_d  = (fill_q == '0) ? StFlush : StRun;
        end
      end
      StRun: begin
        if (drn_gnt) rd_ptr_d = rd_ptr_q + 1'b1;
        if (rd_ptr_d == len_q) state_d = StFlush;
      end
      StFlush: begin
        if (drn_done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset drops any in-flight reads and the drain.
  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      state_q       <= StIdle;
      wr_ptr_q      <= '0;
      fill_q        <= '0;
      len_q         <= '0;
      rd_ptr_q      <= '0;
      overflow_q    <= 1'b0;
      last_host_q   <= 1'b0;
      drn_pend_q    <= 1'b0;
      host_pend_q   <= 1'b0;
      host_oob_q    <= 1'b0;
      host_rvalid_q <= 1'b0;
      host_rdata_q  <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      fill_q        <= fill_d;
      len_q         <= len_d;
      rd_ptr_q      <= rd_ptr_d;
      overflow_q    <= overflow_d;
      last_host_q   <= last_host_d;
      drn_pend_q    <= drn_pend_d;
      host_pend_q   <= host_pend_d;
      host_oob_q    <= host_oob_d;
      host_rvalid_q <= host_rvalid_d;
      host_rdata_q  <= host_rdata_d;
    end
  end

endmodule

// File: tb/tb_buffer_access_arbiter.sv
// Directed bench for buffer_access_arbiter with a behavioural single-port RAM.
module tb_buffer_access_arbiter;

  localparam int DW = 32;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          cap_req, clear, drn_start, drn_ready, host_req;
  logic [DW-1:0] cap_data;
  logic [AW-1:0] host_addr;
  logic          cap_ack, drn_valid, drn_busy, drn_done, host_ack, host_rvalid;
  logic [DW-1:0] drn_data, host_rdata, mem_wdata, mem_rdata;
  logic [AW:0]   fill_count;
  logic          full, overflow, mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] ram [0:4095];

  int n_cmp = 0;
  int n_bad = 0;
  int got, first_k, last_k, done_k, done_cnt, k, dg_cnt, hg_cnt, b2b;
  logic busy_at [0:15];
  logic ack_h1, ack_h2, prev_dg, dg, hold, done_seen;
  logic [DW-1:0] hold_data;

  buffer_access_arbiter dut (
    .s00_axi_aclk   (clk),
    .s00_axi_areset (rst),
    .cap_req        (cap_req),
    .cap_data       (cap_data),
    .cap_ack        (cap_ack),
    .clear          (clear),
    .drn_start      (drn_start),
    .drn_valid      (drn_valid),
    .drn_data       (drn_data),
    .drn_ready      (drn_ready),
    .drn_busy       (drn_busy),
    .drn_done       (drn_done),
    .host_req       (host_req),
    .host_addr      (host_addr),
    .host_ack       (host_ack),
    .host_rvalid    (host_rvalid),
    .host_rdata     (host_rdata),
    .fill_count     (fill_count),
    .full           (full),
    .overflow       (overflow),
    .mem_en         (mem_en),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else mem_rdata <= ram[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; cap_req = 0; cap_data = '0; clear = 0; drn_start = 0;
    drn_ready = 0; host_req = 0; host_addr = '0; mem_rdata = '0;
    #2;
    chk("rst_fill", fill_count, 0);
    chk("rst_busy", drn_busy, 0);
    chk("rst_valid", drn_valid, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_rvalid", host_rvalid, 0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Five captures land at addresses 0..4.
    for (int i = 0; i < 5; i++) begin
      cap_req = 1; cap_data = 32'hA0 + i;
      #1;
      chk("cap_ack", cap_ack, 1);
      chk("cap_we", mem_we, 1);
      chk("cap_addr", mem_addr, i);
      tick();
    end
    cap_req = 0;
    chk("fill5", fill_count, 5);
    chk("full5", full, 0);
    for (int i = 0; i < 5; i++) chk("ram_word", ram[i], 32'hA0 + i);

    // Uncontended drain, sink always ready.
    drn_ready = 1; drn_start = 1;
    tick();
    drn_start = 0;
    got = 0; first_k = -1; last_k = -1; done_k = -1; done_cnt = 0;
    for (int j = 1; j < 12; j++) begin
      busy_at[j] = drn_busy;
      if (drn_valid && drn_ready) begin
        chk("drain1_data", drn_data, 32'hA0 + got);
        if (got == 0) first_k = j;
        last_k = j;
        got++;
      end
      if (drn_done) begin
        done_cnt++;
        done_k = j;
      end
      tick();
    end
    chk("drain1_count", got, 5);
    chk("drain1_first", first_k, 3);
    chk("drain1_last", last_k, 7);
    chk("drain1_done_k", done_k, 8);
    chk("drain1_done_cnt", done_cnt, 1);
    chk("drain1_busy_start", busy_at[1], 1);
    chk("drain1_busy_done", busy_at[8], 1);
    chk("drain1_busy_after", busy_at[9], 0);

    // Drain under backpressure while the host hammers address 2.
    host_req = 1; host_addr = 2; drn_start = 1;
    #1;
    ack_h2 = 0; ack_h1 = host_ack;
    tick();
    drn_start = 0;
    got = 0; dg_cnt = 0; hg_cnt = 0; b2b = 0; prev_dg = 0; hold = 0; done_seen = 0;
    hold_data = '0; k = 1;
    while (!done_seen && k < 60) begin
      drn_ready = k[0];
      #1;
      chk("host_rvalid_timing", host_rvalid, ack_h2);
      if (host_rvalid) chk("host_rdata_a2", host_rdata, 32'hA2);
      if (host_ack) begin
        chk("host_addr2", mem_addr, 2);
        hg_cnt++;
      end
      dg = mem_en && !mem_we && !host_ack;
      if (dg) dg_cnt++;
      if (dg && prev_dg) b2b++;
      prev_dg = dg;
      if (hold) begin
        chk("stall_valid", drn_valid, 1);
        chk("stall_data", drn_data, hold_data);
      end
      hold = drn_valid && !drn_ready;
      hold_data = drn_data;
      if (drn_valid && drn_ready) begin
        chk("drain2_data", drn_data, 32'hA0 + got);
        got++;
      end
      if (drn_done) done_seen = 1;
      ack_h2 = ack_h1; ack_h1 = host_ack;
      tick();
      k++;
    end
    chk("drain2_done", done_seen, 1);
    chk("drain2_count", got, 5);
    chk("drain2_grants", dg_cnt, 5);
    chk("drain2_no_b2b", b2b, 0);
    chk("drain2_host_served", hg_cnt > 0, 1);
    host_req = 0;
    for (int j = 0; j < 2; j++) begin
      #1;
      chk("host_tail_rvalid", host_rvalid, ack_h2);
      if (host_rvalid) chk("host_tail_rdata", host_rdata, 32'hA2);
      ack_h2 = ack_h1; ack_h1 = host_ack;
      tick();
    end
    drn_ready = 1;

    // Host read beyond fill count returns zero.
    host_req = 1; host_addr = 7;
    #1;
    chk("oob_ack", host_ack, 1);
    chk("oob_addr", mem_addr, 7);
    chk("oob_we", mem_we, 0);
    tick();
    host_req = 0;
    chk("oob_rvalid_n1", host_rvalid, 0);
    tick();
    chk("oob_rvalid_n2", host_rvalid, 1);
    chk("oob_rdata", host_rdata, 0);
    tick();

    // Fill to capacity, then one dropped word.
    for (int i = 0; i < 3495; i++) begin
      cap_req = 1; cap_data = i;
      tick();
    end
    cap_req = 0;
    chk("fill_full_cnt", fill_count, 3500);
    chk("fill_full", full, 1);
    chk("fill_no_ovf", overflow, 0);
    chk("fill_last_word", ram[3499], 3494);
    cap_req = 1; cap_data = 32'hDEAD;
    #1;
    chk("drop_ack", cap_ack, 1);
    chk("drop_no_mem", mem_en, 0);
    tick();
    cap_req = 0;
    chk("drop_ovf", overflow, 1);
    chk("drop_fill", fill_count, 3500);
    tick();
    chk("ovf_sticky", overflow, 1);
    clear = 1;
    tick();
    clear = 0;
    chk("clr_fill", fill_count, 0);
    chk("clr_ovf", overflow, 0);
    chk("clr_full", full, 0);

    // Clear and capture together: capture lands at address 0.
    for (int i = 0; i < 3; i++) begin
      cap_req = 1; cap_data = 32'h10 + i;
      tick();
    end
    clear = 1; cap_req = 1; cap_data = 32'h55;
    #1;
    chk("clrcap_addr", mem_addr, 0);
    chk("clrcap_we", mem_we, 1);
    tick();
    clear = 0; cap_req = 0;
    chk("clrcap_fill", fill_count, 1);
    chk("clrcap_ram", ram[0], 32'h55);

    // Reset in the middle of a drain.
    for (int i = 0; i < 4; i++) begin
      cap_req = 1; cap_data = 32'hB1 + i;
      tick();
    end
    cap_req = 0;
    drn_start = 1;
    tick();
    drn_start = 0;
    tick(); tick();
    chk("mid_valid", drn_valid, 1);
    chk("mid_busy", drn_busy, 1);
    rst = 1;
    #1;
    chk("ar_busy", drn_busy, 0);
    chk("ar_valid", drn_valid, 0);
    chk("ar_data", drn_data, 0);
    chk("ar_done", drn_done, 0);
    chk("ar_fill", fill_count, 0);
    chk("ar_full", full, 0);
    chk("ar_ovf", overflow, 0);
    chk("ar_mem_en", mem_en, 0);
    chk("ar_mem_addr", mem_addr, 0);
    chk("ar_rvalid", host_rvalid, 0);
    chk("ar_host_ack", host_ack, 0);
    done_cnt = 0;
    for (int j = 0; j < 3; j++) begin
      tick();
      if (drn_done) done_cnt++;
    end
    chk("ar_no_done", done_cnt, 0);
    rst = 0;
    tick();
    drn_start = 1;
    tick();
    drn_start = 0;
    chk("zero_busy", drn_busy, 1);
    chk("zero_done", drn_done, 1);
    chk("zero_valid", drn_valid, 0);
    tick();
    chk("zero_busy_after", drn_busy, 0);
    chk("zero_done_after", drn_done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/buffer_access_arbiter.md
# buffer_access_arbiter

Arbiter and sequencer for the capture buffer's single-port storage RAM. It serialises three requesters onto one RAM port: sequential capture writes from the accelerator side, a streaming drain read-out, and random host (MMIO) reads. It also owns the write pointer, the fill count and the drain state machine, and sits between the AXI register front-end and the storage array.

## Interface
- DATA_WIDTH, 32, word width
- ADDR_WIDTH, 12, RAM address width; must satisfy 2**ADDR_WIDTH >= DEPTH
- DEPTH, 3500, usable words
- s00_axi_aclk  in  1  clock
- s00_axi_areset  in  1  reset, asynchronous, active-high
- cap_req / cap_data  in  1 / DATA_WIDTH  capture write request, one word per request cycle
- cap_ack  out  1  capture accepted (combinational, same cycle)
- clear  in  1  reset fill count and write pointer
- drn_start  in  1  start draining words 0..fill_count-1
- drn_valid / drn_data  out  1 / DATA_WIDTH  drain stream
- drn_ready  in  1  drain stream backpressure
- drn_busy / drn_done  out  1 / 1  drain active / one-cycle completion pulse
- host_req / host_addr  in  1 / ADDR_WIDTH  host read request
- host_ack  out  1  host request granted (combinational)
- host_rvalid / host_rdata  out  1 / DATA_WIDTH  host read response
- fill_count  out  ADDR_WIDTH+1  words stored
- full / overflow  out  1 / 1  fill_count==DEPTH / sticky write-while-full flag
- mem_en / mem_we / mem_addr / mem_wdata  out  1 / 1 / ADDR_WIDTH / DATA_WIDTH  RAM port, combinational from grant
- mem_rdata  in  DATA_WIDTH  RAM read data, valid one cycle after mem_en with mem_we=0

## Operation
- One grant per cycle. Capture has fixed highest priority. Drain and host share the remaining slot round-robin through a last-grant bit: on a tie, the requester not granted last wins.
- Capture: cap_ack=cap_req every cycle. When not full, the block writes to wr_ptr, then increments wr_ptr and fill_count. When full, the word is dropped, there is no RAM access, and overflow sets. overflow clears only on clear or reset.
- clear: honoured only when drn_busy=0, otherwise ignored. It sets wr_ptr=0, fill_count=0 and overflow=0. If clear and cap_req arrive in the same cycle, clear applies first and the capture writes address 0, giving fill_count=1.
- Host: a granted read with host_addr>=fill_count still issues the RAM read, but host_rdata is forced to 0.
- Drain FSM: IDLE -> RUN -> FLUSH -> IDLE.
  - IDLE: drn_start latches len=fill_count and rd_ptr=0. If len==0, go to FLUSH directly; otherwise go to RUN. drn_start is ignored outside IDLE.
  - RUN: requests a read while rd_ptr<len and (skid occupancy + in-flight)<2. Each grant increments rd_ptr. When rd_ptr==len, go to FLUSH.
  - FLUSH: waits until the skid buffer is empty and nothing is in flight, then pulses drn_done and returns to IDLE.
- Captures during RUN are permitted. They do not extend len.

## Timing
- Grant in cycle N: cap_ack/host_ack and mem_* are active in N. RAM data returns in N+1. host_rvalid/host_rdata are registered and appear in N+2. Drain words enter the skid buffer in N+2.
- drn_valid/drn_data come from the 2-entry skid buffer. A word transfers when drn_valid&&drn_ready. Data stays stable while drn_ready=0.
- drn_busy is high from the cycle after an accepted drn_start through the drn_done cycle inclusive.
- Reset values: all outputs 0 and FSM in IDLE. wr_ptr, rd_ptr, fill_count, overflow, last-grant bit and skid buffer are all cleared.
- Reset asserted mid-drain aborts immediately. Outstanding RAM reads are discarded and no drn_done is issued.
- Sustained drain throughput with drn_ready=1 and no contention: 1 word/cycle after a 2-cycle startup.

## Structure
- Package buffer_arb_pkg:
  - drain state enum (IDLE, RUN, FLUSH)
  - requester id enum (CAP, DRN, HOST)
  - DEPTH default constant
- Sub-module drain_skid_fifo: 2-entry valid/ready buffer with an occupancy output.
- The arbiter, pointers and FSM stay in the top module.

## Test plan
- Reset, then 5 captures of 0xA0..0xA4 -> fill_count=5; RAM holds 0xA0..0xA4 at addresses 0..4; full=0.
- After 5 captures, drn_start with drn_ready=1 -> drn_data 0xA0..0xA4 on 5 consecutive cycles, then drn_done one cycle later; drn_busy falls after drn_done.
- Same drain with drn_ready toggling 1/0 and host_req held at addr 2 -> host grants and drain grants alternate; stream order is preserved; every host_rdata=0xA2 at grant+2; no word lost or duplicated.
- Host read at addr 7 with fill_count=5 -> host_rvalid at grant+2 with host_rdata=0.
- Fill to DEPTH=3500, then one more capture -> full=1, overflow=1, fill_count stays 3500, no RAM write; a later clear -> fill_count=0, overflow=0.
- Assert s00_axi_areset during RUN with 3 words in flight -> all outputs 0 within the same cycle, no drn_done; a new drn_start after reset drains 0 words and pulses drn_done.
